// File: rtl/bbq_egress_reader_pkg.sv
// -----------------------------------------------------------------------------
// BBQctrl package: shared types and constants for the BBQ egress reader.
//   egress_state_t : egress FSM states (IDLE, HDR, STREAM, FETCH, FREE)
//   BBQ_LEN_LSB    : bit position of the packet-length field in a header word
// -----------------------------------------------------------------------------
package BBQctrl;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    STREAM = 3'd2,
    FETCH  = 3'd3,
    FREE   = 3'd4
  } egress_state_t;

  localparam int BBQ_LEN_LSB = 0;

endpackage

// File: rtl/bbq_egress_reader_addr_fifo.sv
// -----------------------------------------------------------------------------
// bbq_addr_fifo: synchronous FIFO for dequeued buffer addresses.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise the word is discarded (the caller flags that as a drop).
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   push, push_data : write request and data
//   pop          : read request (ignored when empty)
//   head         : word at the read pointer (valid when !empty)
//   full, empty  : occupancy flags
// -----------------------------------------------------------------------------
module bbq_addr_fifo #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic [DWIDTH-1:0] mem_r [DEPTH];
  logic              pop_ok_s;
  logic              push_ok_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign head      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; low bits wrap modulo DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Storage write; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/bbq_egress_reader.sv
// -----------------------------------------------------------------------------
// bbq_egress_reader: consumer end of the BBQ dequeue stream.
// Queues dequeued buffer addresses, reads each packet from buffer memory word
// by word (header word first, its low bits give the length in words), streams
// it on a valid/ready egress port, then returns the address to the free list.
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   in_valid, in_buff_addr        : dequeued addresses (no backpressure)
//   ovf                           : sticky, an address was dropped (FIFO full)
//   mem_rd_en/addr, mem_rd_data   : buffer memory read, data 1 cycle later
//   out_valid/ready/data/last     : egress packet stream
//   free_valid/ready, free_addr   : address return to the free-list manager
// Optional build macro BBQ_EGRESS_STATS_EN adds stat_pkts, stat_words and a
// saturating stat_drops counter.
// -----------------------------------------------------------------------------
module bbq_egress_reader
  import BBQctrl::*;
#(
  parameter int HEAP_ENTRY_DWIDTH = 32,
  parameter int OUT_BUFF_SIZE     = 16,
  parameter int PKT_DWIDTH        = 64,
  parameter int WORD_AWIDTH       = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic [HEAP_ENTRY_DWIDTH-1:0]         in_buff_addr,
  output logic                                 ovf,
  output logic                                 mem_rd_en,
  output logic [HEAP_ENTRY_DWIDTH+WORD_AWIDTH-1:0] mem_rd_addr,
  input  logic [PKT_DWIDTH-1:0]                mem_rd_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [PKT_DWIDTH-1:0]                out_data,
  output logic                                 out_last,
  output logic                                 free_valid,
  input  logic                                 free_ready,
  output logic [HEAP_ENTRY_DWIDTH-1:0]         free_addr
`ifdef BBQ_EGRESS_STATS_EN
  ,
  output logic [31:0]                          stat_pkts,
  output logic [31:0]                          stat_words,
  output logic [15:0]                          stat_drops
`endif
);

  localparam int RAW_W = HEAP_ENTRY_DWIDTH + WORD_AWIDTH;
  localparam int MAX_WORDS_I = 1 << WORD_AWIDTH;
  localparam logic [WORD_AWIDTH:0] MAX_WORDS = MAX_WORDS_I[WORD_AWIDTH:0];
  localparam int ONE_I = 1;
  localparam logic [WORD_AWIDTH:0] LEN_ONE = ONE_I[WORD_AWIDTH:0];

  // Zero-length headers still carry one word; oversize lengths fill the slot.
  function automatic logic [WORD_AWIDTH:0] clamp_len(input logic [WORD_AWIDTH:0] raw);
    logic [WORD_AWIDTH:0] len;
    if (raw == '0) begin
      len = LEN_ONE;
    end else if (raw > MAX_WORDS) begin
      len = MAX_WORDS;
    end else begin
      len = raw;
    end
    return len;
  endfunction

  egress_state_t               state_r, state_nxt_s;
  logic [HEAP_ENTRY_DWIDTH-1:0] cur_addr_r, cur_addr_nxt_s;
  logic [WORD_AWIDTH-1:0]      word_idx_r, word_idx_nxt_s;
  logic [WORD_AWIDTH:0]        len_r, len_nxt_s;
  logic [WORD_AWIDTH:0]        hdr_len_s;
  logic [PKT_DWIDTH-1:0]       out_data_r, out_data_nxt_s;
  logic                        out_valid_r, out_valid_nxt_s;
  logic                        out_last_r, out_last_nxt_s;
  logic                        free_valid_r, free_valid_nxt_s;
  logic [HEAP_ENTRY_DWIDTH-1:0] free_addr_r, free_addr_nxt_s;
  logic [RAW_W-1:0]            rd_addr_r, rd_addr_s;
  logic                        rd_en_s;
  logic                        ovf_r;
  logic                        fifo_pop_s;
  logic [HEAP_ENTRY_DWIDTH-1:0] fifo_head_s;
  logic                        fifo_full_s;
  logic                        fifo_empty_s;
  logic                        drop_s;

  bbq_addr_fifo #(
    .DWIDTH (HEAP_ENTRY_DWIDTH),
    .DEPTH  (OUT_BUFF_SIZE)
  ) u_addr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_buff_addr),
    .pop       (fifo_pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Same condition the FIFO uses to refuse a push.
  assign drop_s    = in_valid && fifo_full_s && !fifo_pop_s;
  assign hdr_len_s = clamp_len(mem_rd_data[BBQ_LEN_LSB +: WORD_AWIDTH+1]);

  // The read strobe is issued in the deciding cycle so data lands one cycle later.
  assign mem_rd_en   = rd_en_s;
  assign mem_rd_addr = rd_addr_s;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_last    = out_last_r;
  assign free_valid  = free_valid_r;
  assign free_addr   = free_addr_r;
  assign ovf         = ovf_r;

  // Egress FSM next-state and datapath next values.
  always_comb begin
    state_nxt_s      = state_r;
    cur_addr_nxt_s   = cur_addr_r;
    word_idx_nxt_s   = word_idx_r;
    len_nxt_s        = len_r;
    out_data_nxt_s   = out_data_r;
    out_valid_nxt_s  = out_valid_r;
    out_last_nxt_s   = out_last_r;
    free_valid_nxt_s = free_valid_r;
    free_addr_nxt_s  = free_addr_r;
    rd_addr_s        = rd_addr_r;
    rd_en_s          = 1'b0;
    fifo_pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s     = 1'b1;
          cur_addr_nxt_s = fifo_head_s;
          word_idx_nxt_s = '0;
          rd_en_s        = 1'b1;
          rd_addr_s      = {fifo_head_s, {WORD_AWIDTH{1'b0}}};
          state_nxt_s    = HDR;
        end else begin
          state_nxt_s    = IDLE;
        end
      end
      HDR: begin
        out_data_nxt_s  = mem_rd_data;
        len_nxt_s       = hdr_len_s;
        out_valid_nxt_s = 1'b1;
        out_last_nxt_s  = (hdr_len_s == LEN_ONE);
        state_nxt_s     = STREAM;
      end
      STREAM: begin
        if (out_ready && !out_last_r) begin
          out_valid_nxt_s = 1'b0;
          word_idx_nxt_s  = word_idx_r + WORD_AWIDTH'(1);
          rd_en_s         = 1'b1;
          rd_addr_s       = {cur_addr_r, word_idx_r + WORD_AWIDTH'(1)};
          state_nxt_s     = FETCH;
        end else if (out_ready) begin
          out_valid_nxt_s  = 1'b0;
          out_last_nxt_s   = 1'b0;
          free_valid_nxt_s = 1'b1;
          free_addr_nxt_s  = cur_addr_r;
          state_nxt_s      = FREE;
        end else begin
          state_nxt_s      = STREAM;
        end
      end
      FETCH: begin
        out_data_nxt_s  = mem_rd_data;
        out_valid_nxt_s = 1'b1;
        out_last_nxt_s  = ({1'b0, word_idx_r} == (len_r - LEN_ONE));
        state_nxt_s     = STREAM;
      end
      FREE: begin
        if (free_ready) begin
          free_valid_nxt_s = 1'b0;
          state_nxt_s      = IDLE;
        end else begin
          state_nxt_s      = FREE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Egress FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr_r   <= '0;
      word_idx_r   <= '0;
      len_r        <= '0;
      out_data_r   <= '0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      free_valid_r <= 1'b0;
      free_addr_r  <= '0;
      rd_addr_r    <= '0;
    end else begin
      cur_addr_r   <= cur_addr_nxt_s;
      word_idx_r   <= word_idx_nxt_s;
      len_r        <= len_nxt_s;
      out_data_r   <= out_data_nxt_s;
      out_valid_r  <= out_valid_nxt_s;
      out_last_r   <= out_last_nxt_s;
      free_valid_r <= free_valid_nxt_s;
      free_addr_r  <= free_addr_nxt_s;
      rd_addr_r    <= rd_addr_s;
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end
  end

`ifdef BBQ_EGRESS_STATS_EN
  logic [31:0] stat_pkts_r;
  logic [31:0] stat_words_r;
  logic [15:0] stat_drops_r;

  assign stat_pkts  = stat_pkts_r;
  assign stat_words = stat_words_r;
  assign stat_drops = stat_drops_r;

  // Packet/word counters wrap; the drop counter saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_pkts_r  <= 32'd0;
      stat_words_r <= 32'd0;
      stat_drops_r <= 16'd0;
    end else begin
      if (free_valid_r && free_ready) begin
        stat_pkts_r <= stat_pkts_r + 32'd1;
      end
      if (out_valid_r && out_ready) begin
        stat_words_r <= stat_words_r + 32'd1;
      end
      if (drop_s && (stat_drops_r != 16'hFFFF)) begin
        stat_drops_r <= stat_drops_r + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bbq_egress_reader.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for bbq_egress_reader.
// A behavioural buffer memory answers reads one cycle after mem_rd_en; a
// negedge monitor records read addresses, egress words and freed addresses.
// -----------------------------------------------------------------------------
module tb_bbq_egress_reader;

  localparam int HW = 32;
  localparam int PW = 64;
  localparam int WA = 4;
  localparam int AW = HW + WA;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [HW-1:0] in_buff_addr;
  logic          ovf;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [PW-1:0] mem_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic          out_last;
  logic          free_valid;
  logic          free_ready;
  logic [HW-1:0] free_addr;
`ifdef BBQ_EGRESS_STATS_EN
  logic [31:0]   stat_pkts;
  logic [31:0]   stat_words;
  logic [15:0]   stat_drops;
`endif

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0] mem [logic [AW-1:0]];
  logic          sampled_en = 1'b0;
  logic [AW-1:0] sampled_addr = '0;
  logic [PW-1:0] out_q  [$];
  logic          last_q [$];
  logic [AW-1:0] rd_q   [$];
  logic [HW-1:0] free_q [$];

  always #5 clk = ~clk;

  bbq_egress_reader dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_buff_addr (in_buff_addr),
    .ovf          (ovf),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .free_valid   (free_valid),
    .free_ready   (free_ready),
    .free_addr    (free_addr)
`ifdef BBQ_EGRESS_STATS_EN
    ,
    .stat_pkts    (stat_pkts),
    .stat_words   (stat_words),
    .stat_drops   (stat_drops)
`endif
  );

  function automatic logic [PW-1:0] rd_mem(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {28'hBAD0000, a};
  endfunction

  // Monitor: sample away from the rising edge.
  always @(negedge clk) begin
    sampled_en   = mem_rd_en;
    sampled_addr = mem_rd_addr;
    if (rst) begin
      if (mem_rd_en) rd_q.push_back(mem_rd_addr);
      if (out_valid && out_ready) begin
        out_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      if (free_valid && free_ready) free_q.push_back(free_addr);
    end
  end

  // Buffer memory: data valid exactly one cycle after the read strobe.
  always @(posedge clk) begin
    mem_rd_data <= sampled_en ? rd_mem(sampled_addr) : 64'hDEAD_DEAD_DEAD_DEAD;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [HW-1:0] a);
    in_valid     = 1'b1;
    in_buff_addr = a;
    step();
    in_valid     = 1'b0;
    in_buff_addr = '0;
  endtask

  task automatic clear_q();
    out_q.delete();
    last_q.delete();
    rd_q.delete();
    free_q.delete();
  endtask

  task automatic wait_frees(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (free_q.size() < n && c < budget) begin
      step();
      c++;
    end
    chk(tag, 64'(free_q.size()), 64'(n));
  endtask

  task automatic wait_out_valid(input string tag, input int budget);
    int c;
    c = 0;
    while (!out_valid && c < budget) begin
      step();
      c++;
    end
    chk(tag, 64'(out_valid), 64'd1);
  endtask

  task automatic wait_free_valid(input string tag, input int budget);
    int c;
    c = 0;
    while (!free_valid && c < budget) begin
      step();
      c++;
    end
    chk(tag, 64'(free_valid), 64'd1);
  endtask

  initial begin
    rst          = 1'b0;
    in_valid     = 1'b0;
    in_buff_addr = '0;
    out_ready    = 1'b0;
    free_ready   = 1'b0;

    // Memory image.
    mem[36'h50] = 64'h1111_0000_0000_0003;   // header len=3
    mem[36'h51] = 64'hAAAA_AAAA_0000_0001;   // A
    mem[36'h52] = 64'hBBBB_BBBB_0000_0002;   // B
    mem[36'h70] = 64'h1234_5678_9ABC_DE00;   // header len=0
    mem[36'h90] = 64'hC1A3_0000_0000_001F;   // header len=31, clamped to 16
    for (int i = 1; i < 16; i++) mem[{32'h9, 4'(i)}] = 64'hD000_0000_0000_0000 | 64'(i);
    mem[36'h30] = 64'h3333_0000_0000_0004;   // header len=4
    for (int i = 1; i < 4; i++) mem[{32'h3, 4'(i)}] = 64'h3333_0000_0000_0000 | 64'(i);
    for (int a = 16; a <= 34; a++) mem[{32'(a), 4'h0}] = 64'h5100_0000_0000_0001 | (64'(a) << 8);

    // Reset state.
    repeat (3) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
    chk("rst_free_valid", 64'(free_valid), 64'd0);
    chk("rst_free_addr", 64'(free_addr), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b1;
    step();
    step();

    // Basic three-word packet at 0x5, with latency checks.
    out_ready  = 1'b1;
    free_ready = 1'b1;
    clear_q();
    push1(32'h5);
    chk("t1_rd_en_first", 64'(mem_rd_en), 64'd1);
    chk("t1_rd_addr_first", 64'(mem_rd_addr), 64'h50);
    step();
    chk("t1_valid_not_yet", 64'(out_valid), 64'd0);
    step();
    chk("t1_valid_at_2", 64'(out_valid), 64'd1);
    chk("t1_hdr_data", out_data, 64'h1111_0000_0000_0003);
    wait_frees("t1_free_done", 1, 50);
    chk("t1_nwords", 64'(out_q.size()), 64'd3);
    chk("t1_nreads", 64'(rd_q.size()), 64'd3);
    if (out_q.size() == 3 && rd_q.size() == 3) begin
      chk("t1_w0", out_q[0], 64'h1111_0000_0000_0003);
      chk("t1_w1", out_q[1], 64'hAAAA_AAAA_0000_0001);
      chk("t1_w2", out_q[2], 64'hBBBB_BBBB_0000_0002);
      chk("t1_last0", 64'(last_q[0]), 64'd0);
      chk("t1_last1", 64'(last_q[1]), 64'd0);
      chk("t1_last2", 64'(last_q[2]), 64'd1);
      chk("t1_rd0", 64'(rd_q[0]), 64'h50);
      chk("t1_rd1", 64'(rd_q[1]), 64'h51);
      chk("t1_rd2", 64'(rd_q[2]), 64'h52);
    end
    if (free_q.size() >= 1) chk("t1_free_addr", 64'(free_q[0]), 64'h5);
    step();

    // len=0 header is a single-word packet.
    clear_q();
    push1(32'h7);
    wait_frees("t2_free_done", 1, 50);
    chk("t2_nwords", 64'(out_q.size()), 64'd1);
    if (out_q.size() == 1) begin
      chk("t2_w0", out_q[0], 64'h1234_5678_9ABC_DE00);
      chk("t2_last0", 64'(last_q[0]), 64'd1);
    end
    if (free_q.size() >= 1) chk("t2_free_addr", 64'(free_q[0]), 64'h7);
    step();

    // Oversized length is clamped to 16 words.
    clear_q();
    push1(32'h9);
    wait_frees("t3_free_done", 1, 120);
    chk("t3_nwords", 64'(out_q.size()), 64'd16);
    chk("t3_nreads", 64'(rd_q.size()), 64'd16);
    if (out_q.size() == 16 && rd_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("t3_w%0d", i), out_q[i],
            (i == 0) ? 64'hC1A3_0000_0000_001F : (64'hD000_0000_0000_0000 | 64'(i)));
        chk($sformatf("t3_last%0d", i), 64'(last_q[i]), (i == 15) ? 64'd1 : 64'd0);
        chk($sformatf("t3_rd%0d", i), 64'(rd_q[i]), 64'h90 + 64'(i));
      end
    end
    if (free_q.size() >= 1) chk("t3_free_addr", 64'(free_q[0]), 64'h9);
    step();

    // Egress backpressure for 5 cycles mid-packet.
    out_ready = 1'b0;
    clear_q();
    push1(32'h3);
    wait_out_valid("t4_hdr_valid", 20);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    wait_out_valid("t4_w1_valid", 20);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_data", out_data, 64'h3333_0000_0000_0001);
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      chk("t4_hold_reads", 64'(rd_q.size()), 64'd2);
      step();
    end
    out_ready = 1'b1;
    wait_frees("t4_free_done", 1, 50);
    chk("t4_nwords", 64'(out_q.size()), 64'd4);
    chk("t4_nreads", 64'(rd_q.size()), 64'd4);
    if (out_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t4_w%0d", i), out_q[i],
            (i == 0) ? 64'h3333_0000_0000_0004 : (64'h3333_0000_0000_0000 | 64'(i)));
        chk($sformatf("t4_last%0d", i), 64'(last_q[i]), (i == 3) ? 64'd1 : 64'd0);
      end
    end
    step();

    // Free-list stall, full FIFO, push+pop when full, then a drop.
    out_ready  = 1'b1;
    free_ready = 1'b0;
    clear_q();
    push1(32'h10);
    wait_free_valid("t5_stall_free", 20);
    for (int a = 17; a <= 32; a++) push1(32'(a));
    chk("t5_ovf_full_no_drop", 64'(ovf), 64'd0);
    free_ready = 1'b1;
    step();
    free_ready = 1'b0;
    chk("t5_pop_cycle", 64'(mem_rd_en), 64'd1);
    in_valid     = 1'b1;
    in_buff_addr = 32'h21;
    step();
    in_valid     = 1'b0;
    in_buff_addr = '0;
    chk("t5_ovf_push_pop", 64'(ovf), 64'd0);
    wait_free_valid("t5_stall_free2", 20);
    push1(32'h22);
    chk("t5_ovf_drop", 64'(ovf), 64'd1);
    free_ready = 1'b1;
    wait_frees("t5_free_done", 18, 400);
    repeat (10) step();
    chk("t5_nfrees", 64'(free_q.size()), 64'd18);
    chk("t5_nwords", 64'(out_q.size()), 64'd18);
    if (free_q.size() == 18 && out_q.size() == 18) begin
      for (int i = 0; i < 18; i++) begin
        chk($sformatf("t5_free%0d", i), 64'(free_q[i]), 64'h10 + 64'(i));
        chk($sformatf("t5_w%0d", i), out_q[i],
            64'h5100_0000_0000_0001 | ((64'h10 + 64'(i)) << 8));
      end
    end
    chk("t5_ovf_sticky", 64'(ovf), 64'd1);

    // Reset asserted mid-STREAM.
    out_ready  = 1'b0;
    free_ready = 1'b1;
    clear_q();
    push1(32'h3);
    push1(32'h7);
    wait_out_valid("t6_streaming", 20);
    rst = 1'b0;
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_out_data", out_data, 64'd0);
    chk("t6_rst_out_last", 64'(out_last), 64'd0);
    chk("t6_rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    chk("t6_rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
    chk("t6_rst_free_valid", 64'(free_valid), 64'd0);
    chk("t6_rst_free_addr", 64'(free_addr), 64'd0);
    chk("t6_rst_ovf", 64'(ovf), 64'd0);
    step();
    step();
    rst = 1'b1;
    clear_q();
    repeat (5) step();
    chk("t6_fifo_empty", 64'(rd_q.size()), 64'd0);
    chk("t6_idle_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    push1(32'h5);
    wait_frees("t6_free_done", 1, 50);
    chk("t6_nwords", 64'(out_q.size()), 64'd3);
    if (out_q.size() == 3) begin
      chk("t6_w0", out_q[0], 64'h1111_0000_0000_0003);
      chk("t6_w2", out_q[2], 64'hBBBB_BBBB_0000_0002);
      chk("t6_last2", 64'(last_q[2]), 64'd1);
    end
    if (free_q.size() >= 1) chk("t6_free_addr", 64'(free_q[0]), 64'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bbq_egress_reader.md
Name: bbq_egress_reader

Overview:
- Consumer end of the BBQ controller's dequeue stream.
- Accepts buffer addresses emitted on the controller's out_valid/out_buff_addr, buffers them in an address FIFO, reads each packet out of packet buffer memory word by word, and streams it on a valid/ready egress port.
- After the last word of a packet is accepted, returns that buffer address to the free-list manager.

Parameters:
- HEAP_ENTRY_DWIDTH, 32, buffer-address width; matches the controller.
- OUT_BUFF_SIZE, 16, address FIFO depth; power of two, ≥2.
- PKT_DWIDTH, 64, packet data word width.
- WORD_AWIDTH, 4, log2 of max words per buffer slot (MAX_WORDS = 16).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  dequeued address valid; no backpressure
- in_buff_addr  in  HEAP_ENTRY_DWIDTH  dequeued buffer address
- ovf  out  1  sticky: an address was dropped because the FIFO was full
- mem_rd_en  out  1  buffer memory read strobe
- mem_rd_addr  out  HEAP_ENTRY_DWIDTH+WORD_AWIDTH  {buff_addr, word_idx}
- mem_rd_data  in  PKT_DWIDTH  read data, valid exactly 1 cycle after mem_rd_en
- out_valid  out  1  egress word valid
- out_ready  in  1  egress consumer ready
- out_data  out  PKT_DWIDTH  egress word
- out_last  out  1  final word of the packet
- free_valid  out  1  freed address valid
- free_ready  in  1  free list accepts the address
- free_addr  out  HEAP_ENTRY_DWIDTH  address being freed

Behaviour:
- Reset (rst=0, async): FIFO empty, FSM IDLE; every output is 0, including ovf and any counters.
- Address FIFO:
  - Push on in_valid.
  - When full, the push is accepted only if a pop occurs in the same cycle. Otherwise the address is dropped and ovf is set until reset.
  - Read and write pointers wrap modulo OUT_BUFF_SIZE.
- FSM (egress_state_t):
  - IDLE: when the FIFO is non-empty, pop into cur_addr, assert mem_rd_en with word_idx=0, go to HDR.
  - HDR: capture mem_rd_data into the output register.
    - len = mem_rd_data[WORD_AWIDTH:0] is the packet length in words, header included.
    - len=0 is treated as 1; len>MAX_WORDS is clamped to MAX_WORDS.
    - Set out_valid, and set out_last if len==1. Go to STREAM.
  - STREAM: hold out_data, out_valid and out_last stable until out_ready.
    - On a handshake with !out_last: deassert out_valid, assert mem_rd_en with word_idx+1, go to FETCH.
    - On a handshake with out_last: go to FREE.
  - FETCH: capture mem_rd_data, set out_valid, set out_last if word_idx==len-1, go to STREAM.
  - FREE: free_valid=1 and free_addr=cur_addr, held until free_ready. On handshake go to IDLE; the next pop is allowed the following cycle.
- Latency:
  - FIFO non-empty to first out_valid: 2 cycles.
  - Steady-state throughput: 1 word per 2 cycles with out_ready tied high.
  - Packet overhead: one FREE cycle plus one IDLE cycle.
- mem_rd_en is a single-cycle pulse. mem_rd_addr is held between reads (don't-care when idle).
- out_valid never drops without a handshake, per valid/ready rules.
- Free-list backpressure stalls the FSM in FREE. The FIFO keeps absorbing addresses and drops new ones once full.
- Packets are emitted strictly in FIFO (dequeue) order.

Optional Feature:
- BBQ_EGRESS_STATS_EN:
  - When defined, adds outputs stat_pkts (32) and stat_words (32).
  - stat_pkts increments on each free handshake; stat_words increments on each out handshake.
  - Also adds stat_drops (16): saturating count of dropped addresses.
  - All counters reset to 0 and wrap, except stat_drops, which saturates.
- Undefined: these ports and counters are absent; core behaviour is identical.

Decomposition:
- Package BBQctrl gains:
  - egress_state_t (IDLE, HDR, STREAM, FETCH, FREE)
  - BBQ_LEN_LSB = 0
- Sub-module bbq_addr_fifo: parameterised synchronous FIFO with full/empty flags and a simultaneous push/pop-when-full rule; instantiated once.

Test Plan:
- Push addr 0x5 once; memory at 0x5 holds header len=3 plus words A,B; out_ready=1.
  - Expect out_data {hdr, A, B}, out_last only on B.
  - Expect mem_rd_addr 0x50, 0x51, 0x52.
  - Expect free_addr=0x5 with free_ready=1.
- Header with len=0 at addr 0x7: expect a single word with out_last=1, then a free of 0x7.
- Hold out_ready=0 for 5 cycles mid-packet: out_data stable, no extra mem_rd_en, no word lost or duplicated.
- Hold free_ready=0 while pushing 17 addresses: first 16 queued, 17th dropped, ovf=1; order is preserved after release.
- With the FIFO full, push and pop in the same cycle: push accepted, ovf stays 0.
- Assert rst mid-STREAM: all outputs 0 immediately, FIFO empty; resumes correctly with a new address after release.
